rx_bit_sequencer: RTL and testbench

RX_BIT_SEQUENCER -- requirements
Module: rx_bit_sequencer

---
 rtl/rx_bit_sequencer.sv | 143 ++++++++++++++
 tb/tb_rx_bit_sequencer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/rx_bit_sequencer.sv
// 8N1 UART receive sequencer: synchronizes rx, samples at mid-bit and holds the last good byte.
// Consumer handshake is data_valid/rd_ack; overrun and frame_err flag lost and malformed bytes.
module rx_bit_sequencer #(
  parameter int BIT_CLKS = 10402
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       rd_ack,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       overrun,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = $clog2(BIT_CLKS);
  localparam logic [CW-1:0] HALF_M1 = CW'(BIT_CLKS / 2 - 1);
  localparam logic [CW-1:0] BIT_M1  = CW'(BIT_CLKS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic          sync1_q, rx_s_q;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          dv_q, dv_d;
  logic          ovr_q, ovr_d;
  logic          ferr_q, ferr_d;
  logic          byte_done;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    dv_d      = dv_q;
    ovr_d     = ovr_q;
    ferr_d    = 1'b0;
    byte_done = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        // Start bit must still be low at its centre, otherwise it was a glitch.
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            state_d   = S_DATA;
            bit_idx_d = 3'd0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_M1) begin
          cnt_d     = '0;
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_M1) begin
          cnt_d = '0;
          if (rx_s_q) begin
            byte_done = 1'b1;
            state_d   = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_BREAK: begin
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A completing byte wins over an acknowledge; an ack on that edge only suppresses overrun.
    if (byte_done) begin
      data_d = shift_q;
      dv_d   = 1'b1;
      ovr_d  = dv_q ? ~rd_ack : ovr_q;
    end else if (rd_ack && dv_q) begin
      dv_d  = 1'b0;
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      dv_q      <= 1'b0;
      ovr_q     <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      sync1_q   <= rx;
      rx_s_q    <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      dv_q      <= dv_d;
      ovr_q     <= ovr_d;
      ferr_q    <= ferr_d;
    end
  end

  assign data       = data_q;
  assign data_valid = dv_q;
  assign overrun    = ovr_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_rx_bit_sequencer.sv
// Directed bench for rx_bit_sequencer at BIT_CLKS=16: good frame, glitch, framing error,
// overrun/ack collision and reset mid-frame, with a byte scoreboard.
module tb_rx_bit_sequencer;
  localparam int BC = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       rd_ack = 1'b0;
  logic [7:0] data;
  logic       data_valid, overrun, frame_err, busy;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  rx_bit_sequencer #(.BIT_CLKS(BC)) dut (
    .clk(clk), .reset(reset), .rx(rx), .rd_ack(rd_ack),
    .data(data), .data_valid(data_valid), .overrun(overrun),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Drives one frame starting at a negedge; the start bit is seen at posedge 3 (E0),
  // so the stop sample edge E0+152 is posedge 155 and is checked at negedge 155.
  task automatic send_frame(input logic [7:0] b, input logic stop, input bit timed,
                            input bit ack_at_done, input int abort_at);
    logic [9:0] bits;
    logic [7:0] e;
    bits = {stop, b, 1'b0};
    if (stop && abort_at == 0) exp_q.push_back(b);
    for (int k = 0; k < 10 * BC; k++) begin
      rx = bits[k / BC];
      if (ack_at_done && k == 154) rd_ack = 1'b1;
      if (ack_at_done && k == 155) rd_ack = 1'b0;
      if (abort_at != 0 && k == abort_at) begin
        check1("busy_before_rst", busy, 1'b1);
        #2 reset = 1'b1;
        #1;
        check1("rst_busy", busy, 1'b0);
        check1("rst_dv", data_valid, 1'b0);
        check1("rst_ovr", overrun, 1'b0);
        check1("rst_ferr", frame_err, 1'b0);
        check8("rst_data", data, 8'h00);
        rx = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      @(negedge clk);
      if (timed && k + 1 == 154) begin
        check1("dv_before_stop", data_valid, 1'b0);
        check1("busy_before_stop", busy, 1'b1);
      end
      if (k + 1 == 155) begin
        if (stop) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL sb_empty: observed byte %02h expected none", data);
          end else begin
            e = exp_q.pop_front();
            check8("sb_data", data, e);
          end
          check1("dv_at_stop", data_valid, 1'b1);
          if (timed) begin
            check1("busy_after_stop", busy, 1'b0);
            check1("ferr_good", frame_err, 1'b0);
          end
        end else begin
          check1("ferr_pulse", frame_err, 1'b1);
          check1("ferr_dv", data_valid, 1'b0);
          check1("ferr_busy", busy, 1'b1);
        end
      end
      if (!stop && k + 1 == 156) check1("ferr_one_cycle", frame_err, 1'b0);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check1("reset_busy", busy, 1'b0);
    check1("reset_dv", data_valid, 1'b0);
    check1("reset_ovr", overrun, 1'b0);
    check1("reset_ferr", frame_err, 1'b0);
    check8("reset_data", data, 8'h00);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Good frame
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 0);
    @(negedge clk);
    check1("good_idle", busy, 1'b0);
    check1("good_dv_hold", data_valid, 1'b1);

    // Acknowledge, then acks with nothing held
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
    check1("ack_clears_dv", data_valid, 1'b0);
    check8("ack_data_kept", data, 8'hA5);
    rd_ack = 1'b1;
    repeat (2) @(negedge clk);
    rd_ack = 1'b0;
    check1("idle_ack_dv", data_valid, 1'b0);
    check1("idle_ack_ovr", overrun, 1'b0);
    check1("idle_ack_busy", busy, 1'b0);

    // Glitch: 3 cycles low
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (7) @(negedge clk);
    check1("glitch_start_busy", busy, 1'b1);
    @(negedge clk);
    check1("glitch_back_idle", busy, 1'b0);
    check1("glitch_no_dv", data_valid, 1'b0);
    check8("glitch_data_kept", data, 8'hA5);
    repeat (4) @(negedge clk);

    // Framing error into BREAK
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 0);
    check8("ferr_data_kept", data, 8'hA5);
    check1("break_busy", busy, 1'b1);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    check1("break_exit_idle", busy, 1'b0);
    check1("break_no_dv", data_valid, 1'b0);

    // Overrun, then completion colliding with ack
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, 0);
    check1("ovr_first", overrun, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, 0);
    check1("ovr_set", overrun, 1'b1);
    send_frame(8'h33, 1'b1, 1'b0, 1'b1, 0);
    check1("collide_ovr_clear", overrun, 1'b0);
    check1("collide_dv", data_valid, 1'b1);
    check8("collide_data", data, 8'h33);
    repeat (2) @(negedge clk);

    // Reset during data bit 4, then a clean frame
    send_frame(8'h77, 1'b1, 1'b0, 1'b0, 85);
    repeat (4) @(negedge clk);
    check1("post_rst_idle", busy, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b1, 1'b0, 0);
    check1("post_rst_ovr", overrun, 1'b0);
    check8("sb_drained", 8'(exp_q.size()), 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
